// File: rtl/if_fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, redirect input and the
// valid/ready output towards the IF/ID register.
interface if_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] pc_plus4_out;
  logic [31:0] instruction_out;

  // Fetch unit side
  modport master (
    output imem_req, imem_addr, out_valid, pc_plus4_out, instruction_out,
    input  imem_ready, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, out_ready
  );

  // Memory / pipeline side
  modport slave (
    input  imem_req, imem_addr, out_valid, pc_plus4_out, instruction_out,
    output imem_ready, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps at most one instruction-memory read in flight,
// holds one fetched instruction for IF/ID and squashes in-flight fetches on redirect.
// Optional performance counters are built when IF_FETCH_PERF_CNT_EN is defined.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  if_fetch_unit_if.master bus
`ifdef IF_FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_killed
`endif
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StHold} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] pc4_q, pc4_d;
  logic [31:0] instr_q, instr_d;
  logic        out_valid_q, out_valid_d;
  logic        kill_q, kill_d;

  logic        req;
  logic        accept;
  logic        xfer;
  logic        rvalid_wait;
  logic [31:0] redirect_tgt;

  assign redirect_tgt = bus.redirect_pc & ~32'd3;
  assign xfer         = out_valid_q & bus.out_ready;
  // A new fetch may only issue when the output slot is empty or draining this cycle.
  assign req          = (state_q == StReq) & (~out_valid_q | bus.out_ready);
  assign accept       = req & bus.imem_ready;
  assign rvalid_wait  = (state_q == StWait) & bus.imem_rvalid;

  assign bus.imem_req        = req;
  assign bus.imem_addr       = pc_q;
  assign bus.out_valid       = out_valid_q;
  assign bus.pc_plus4_out    = pc4_q;
  assign bus.instruction_out = instr_q;

  // Next-state logic: redirect overrides everything, otherwise the normal fetch sequence.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    fetch_pc_d  = fetch_pc_q;
    pc4_d       = pc4_q;
    instr_d     = instr_q;
    out_valid_d = out_valid_q;
    kill_d      = kill_q;

    if (xfer) begin
      out_valid_d = 1'b0;
      instr_d     = NOP_INSTR;
    end
    if (accept) begin
      fetch_pc_d = pc_q;
    end

    if (bus.redirect_valid) begin
      pc_d        = redirect_tgt;
      out_valid_d = 1'b0;
      instr_d     = NOP_INSTR;
      case (state_q)
        StIdle, StHold: state_d = StReq;
        StReq: begin
          // Request already accepted by memory: its response must be dropped.
          if (accept) begin
            state_d = StWait;
            kill_d  = 1'b1;
          end
        end
        StWait: begin
          if (bus.imem_rvalid) begin
            state_d = StReq;
            kill_d  = 1'b0;
          end else begin
            kill_d = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end else begin
      case (state_q)
        StIdle: state_d = StReq;
        StReq: begin
          if (out_valid_q && !bus.out_ready) begin
            state_d = StHold;
          end else if (accept) begin
            state_d = StWait;
          end
        end
        StWait: begin
          if (bus.imem_rvalid) begin
            state_d = StReq;
            if (kill_q) begin
              kill_d = 1'b0;
            end else begin
              instr_d     = bus.imem_rdata;
              pc4_d       = fetch_pc_q + 32'd4;
              out_valid_d = 1'b1;
              pc_d        = fetch_pc_q + 32'd4;
            end
          end
        end
        StHold: begin
          if (bus.out_ready) begin
            state_d = StReq;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      pc_q        <= RESET_PC;
      fetch_pc_q  <= RESET_PC;
      pc4_q       <= 32'h0;
      instr_q     <= NOP_INSTR;
      out_valid_q <= 1'b0;
      kill_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      fetch_pc_q  <= fetch_pc_d;
      pc4_q       <= pc4_d;
      instr_q     <= instr_d;
      out_valid_q <= out_valid_d;
      kill_q      <= kill_d;
    end
  end

`ifdef IF_FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_killed_q, perf_killed_d;

  // Count delivered fetches and squashed work (dropped responses or a flushed output slot).
  always_comb begin
    perf_fetched_d = perf_fetched_q;
    perf_killed_d  = perf_killed_q;
    if (rvalid_wait && !kill_q && !bus.redirect_valid) begin
      perf_fetched_d = perf_fetched_q + 32'd1;
    end
    if ((rvalid_wait && (kill_q || bus.redirect_valid)) ||
        (bus.redirect_valid && out_valid_q)) begin
      perf_killed_d = perf_killed_q + 32'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched_q <= 32'h0;
      perf_killed_q  <= 32'h0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_killed_q  <= perf_killed_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_killed  = perf_killed_q;
`else
  logic unused_rvalid_wait;
  assign unused_rvalid_wait = rvalid_wait;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: memory model with configurable latency, scoreboard queues of
// expected accepted addresses and expected IF/ID transfers, table-driven straight-line/stall
// run plus hand-written redirect, reset and PC-wrap sequences.
module tb_if_fetch_unit;
  localparam logic [31:0] K   = 32'hA5A5_0000;
  localparam logic [31:0] NOP = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] instr;
  } out_t;

  typedef struct {
    int unsigned stall;
    logic [31:0] addr;
    logic [31:0] pc4;
    logic [31:0] instr;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  if_fetch_unit_if bus ();
  if_fetch_unit_if wbus ();

`ifdef IF_FETCH_PERF_CNT_EN
  logic [31:0] pf, pk, wpf, wpk;
`endif

  if_fetch_unit #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef IF_FETCH_PERF_CNT_EN
    ,
    .perf_fetched (pf),
    .perf_killed  (pk)
`endif
  );

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(NOP)) dut_w (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (wbus)
`ifdef IF_FETCH_PERF_CNT_EN
    ,
    .perf_fetched (wpf),
    .perf_killed  (wpk)
`endif
  );

  int          n_cmp = 0;
  int          n_err = 0;
  int          n_acc = 0;
  int          n_xfer = 0;
  int          mem_lat = 1;
  bit          pend = 1'b0;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = 32'h0;
  logic [31:0] addr_q[$];
  out_t        data_q[$];
  vec_t        tbl[3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic push_out(input logic [31:0] pc4, input logic [31:0] instr);
    out_t o;
    o.pc4   = pc4;
    o.instr = instr;
    data_q.push_back(o);
  endtask

  // One clock: score accepts/transfers before the edge, then drive the memory response.
  task automatic tick();
    out_t e;
    #1;
    if (bus.imem_req && bus.imem_ready) begin
      n_acc++;
      if (addr_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_accept: got addr %h, required no request", bus.imem_addr);
      end else begin
        chk("imem_addr", bus.imem_addr, addr_q.pop_front());
      end
      pend      = 1'b1;
      pend_cnt  = mem_lat;
      pend_addr = bus.imem_addr;
    end
    if (bus.out_valid && bus.out_ready) begin
      n_xfer++;
      if (data_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_out: got pc4 %h instr %h, required no transfer",
                 bus.pc_plus4_out, bus.instruction_out);
      end else begin
        e = data_q.pop_front();
        chk("pc_plus4_out", bus.pc_plus4_out, e.pc4);
        chk("instruction_out", bus.instruction_out, e.instr);
      end
    end
    @(posedge clk);
    #1;
    bus.redirect_valid = 1'b0;
    bus.imem_rvalid    = 1'b0;
    if (pend) begin
      if (pend_cnt <= 1) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = pend_addr ^ K;
        pend            = 1'b0;
      end else begin
        pend_cnt--;
      end
    end
    #1;
  endtask

  task automatic run_acc(input int target, input string name);
    int t;
    t = 0;
    while (n_acc < target && t < 50) begin
      tick();
      t++;
    end
    chk(name, n_acc, target);
  endtask

  task automatic run_xfer(input int target, input string name);
    int t;
    t = 0;
    while (n_xfer < target && t < 50) begin
      tick();
      t++;
    end
    chk(name, n_xfer, target);
  endtask

  task automatic chk_drained(input string name);
    chk({name, "_addr_q"}, addr_q.size(), 0);
    chk({name, "_data_q"}, data_q.size(), 0);
  endtask

  task automatic do_reset();
    rst_n              = 1'b0;
    bus.imem_ready     = 1'b0;
    bus.out_ready      = 1'b0;
    bus.redirect_valid = 1'b0;
    tick();
    tick();
    addr_q.delete();
    data_q.delete();
    pend            = 1'b0;
    bus.imem_rvalid = 1'b0;
    n_acc           = 0;
    n_xfer          = 0;
    mem_lat         = 1;
    rst_n           = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    bus.imem_ready      = 1'b0;
    bus.imem_rvalid     = 1'b0;
    bus.imem_rdata      = 32'h0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = 32'h0;
    bus.out_ready       = 1'b0;
    wbus.imem_ready     = 1'b0;
    wbus.imem_rvalid    = 1'b0;
    wbus.imem_rdata     = 32'h0;
    wbus.redirect_valid = 1'b0;
    wbus.redirect_pc    = 32'h0;
    wbus.out_ready      = 1'b0;

    tbl[0] = '{5, 32'h0000_0000, 32'h0000_0004, 32'hA5A5_0000};
    tbl[1] = '{0, 32'h0000_0004, 32'h0000_0008, 32'hA5A5_0004};
    tbl[2] = '{0, 32'h0000_0008, 32'h0000_000C, 32'hA5A5_0008};

    // Reset state
    do_reset();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_imem_req", 32'(bus.imem_req), 32'd0);
    chk("rst_imem_addr", bus.imem_addr, 32'h0);
    chk("rst_pc4", bus.pc_plus4_out, 32'h0);
    chk("rst_instr", bus.instruction_out, NOP);

    // Straight-line fetch with a 5-cycle stall on the first instruction
    for (int i = 0; i < 3; i++) begin
      addr_q.push_back(tbl[i].addr);
      push_out(tbl[i].pc4, tbl[i].instr);
    end
    addr_q.push_back(32'h0000_000C);
    bus.imem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.out_ready = (tbl[i].stall == 0);
      t = 0;
      while (!bus.out_valid && t < 20) begin
        tick();
        t++;
      end
      chk($sformatf("rec%0d_out_valid", i), 32'(bus.out_valid), 32'd1);
      for (int s = 0; s < int'(tbl[i].stall); s++) begin
        #1;
        chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
        chk("stall_pc4", bus.pc_plus4_out, tbl[i].pc4);
        chk("stall_instr", bus.instruction_out, tbl[i].instr);
        chk("stall_imem_req", 32'(bus.imem_req), 32'd0);
        tick();
      end
      bus.out_ready = 1'b1;
      run_xfer(i + 1, $sformatf("rec%0d_xfer", i));
      if (tbl[i].stall != 0) begin
        #1;
        chk("refetch_req", 32'(bus.imem_req), 32'd1);
        chk("refetch_addr", bus.imem_addr, tbl[i].addr + 32'd4);
      end
    end
    chk_drained("straight");

    // Redirect while the fetch of 8 is outstanding
    do_reset();
    mem_lat        = 3;
    bus.imem_ready = 1'b1;
    bus.out_ready  = 1'b1;
    addr_q.push_back(32'h0);
    addr_q.push_back(32'h4);
    addr_q.push_back(32'h8);
    addr_q.push_back(32'h100);
    addr_q.push_back(32'h104);
    push_out(32'h4, K);
    push_out(32'h8, K ^ 32'h4);
    push_out(32'h104, K ^ 32'h100);
    run_acc(3, "b_acc8");
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0103;
    tick();
    #1;
    chk("b_no_stale", 32'(bus.out_valid), 32'd0);
    run_xfer(3, "b_xfer");
    chk_drained("redir_wait");

    // Redirect in the same cycle as rvalid
    do_reset();
    bus.imem_ready = 1'b1;
    bus.out_ready  = 1'b1;
    addr_q.push_back(32'h0);
    addr_q.push_back(32'h200);
    addr_q.push_back(32'h204);
    push_out(32'h204, K ^ 32'h200);
    run_acc(1, "c_acc0");
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0200;
    tick();
    #1;
    chk("c_no_stale", 32'(bus.out_valid), 32'd0);
    run_xfer(1, "c_xfer");
    chk_drained("redir_rvalid");

    // Redirect in REQ without acceptance, then coincident with acceptance
    do_reset();
    bus.out_ready = 1'b1;
    t = 0;
    while (!bus.imem_req && t < 10) begin
      tick();
      t++;
    end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0400;
    tick();
    #1;
    chk("d_new_addr", bus.imem_addr, 32'h400);
    chk("d_req_kept", 32'(bus.imem_req), 32'd1);
    addr_q.push_back(32'h400);
    addr_q.push_back(32'h300);
    addr_q.push_back(32'h304);
    push_out(32'h304, K ^ 32'h300);
    bus.imem_ready     = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0302;
    tick();
    #1;
    chk("d_no_stale0", 32'(bus.out_valid), 32'd0);
    tick();
    #1;
    chk("d_no_stale1", 32'(bus.out_valid), 32'd0);
    run_xfer(1, "d_xfer");
    chk_drained("redir_accept");

    // Async reset while waiting for the fetch of 8; its late rvalid must be ignored
    do_reset();
    mem_lat        = 3;
    bus.imem_ready = 1'b1;
    bus.out_ready  = 1'b1;
    addr_q.push_back(32'h0);
    addr_q.push_back(32'h4);
    addr_q.push_back(32'h8);
    push_out(32'h4, K);
    push_out(32'h8, K ^ 32'h4);
    run_acc(3, "e_acc8");
    #1;
    rst_n = 1'b0;
    #1;
    chk("e_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("e_rst_imem_req", 32'(bus.imem_req), 32'd0);
    chk("e_rst_imem_addr", bus.imem_addr, 32'h0);
    chk("e_rst_pc4", bus.pc_plus4_out, 32'h0);
    chk("e_rst_instr", bus.instruction_out, NOP);
    bus.imem_ready = 1'b0;
    addr_q.delete();
    data_q.delete();
    n_acc  = 0;
    n_xfer = 0;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    #1;
    chk("e_stray_ignored", 32'(bus.out_valid), 32'd0);
    chk("e_first_addr", bus.imem_addr, 32'h0);
    mem_lat = 1;
    addr_q.push_back(32'h0);
    addr_q.push_back(32'h4);
    push_out(32'h4, K);
    bus.imem_ready = 1'b1;
    run_xfer(1, "e_xfer");
    chk_drained("reset_wait");

    // PC wrap on the second instance
    do_reset();
    #1;
    chk("w_idle_req", 32'(wbus.imem_req), 32'd0);
    chk("w_rst_addr", wbus.imem_addr, 32'hFFFF_FFFC);
    wbus.imem_ready = 1'b1;
    wbus.out_ready  = 1'b1;
    @(posedge clk);
    #2;
    chk("w_req", 32'(wbus.imem_req), 32'd1);
    chk("w_addr0", wbus.imem_addr, 32'hFFFF_FFFC);
    @(posedge clk);
    #1;
    wbus.imem_rvalid = 1'b1;
    wbus.imem_rdata  = 32'hFFFF_FFFC ^ K;
    #1;
    chk("w_wait_req", 32'(wbus.imem_req), 32'd0);
    @(posedge clk);
    #1;
    wbus.imem_rvalid = 1'b0;
    #1;
    chk("w_out_valid", 32'(wbus.out_valid), 32'd1);
    chk("w_pc4", wbus.pc_plus4_out, 32'h0);
    chk("w_instr", wbus.instruction_out, 32'h5A5A_FFFC);
    chk("w_addr1", wbus.imem_addr, 32'h0);
    chk("w_req1", 32'(wbus.imem_req), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
